// File: rtl/control_execute_stage_if.sv
// Bundled decode/ID-EX/forwarding/EX-MEM signals between the pipeline control
// logic (master) and the decoder + execute stage (slave).
interface control_execute_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic [3:0]        opcode;
  logic [8:0]        ctrl;
  logic [8:0]        ex_ctrl;
  logic [DATA_W-1:0] pc4;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] ext_imm;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [DATA_W-1:0] fwd_mem;
  logic [DATA_W-1:0] fwd_wb;
  logic [4:0]        mem_ctrl;
  logic [DATA_W-1:0] mem_target;
  logic              mem_zero;
  logic [DATA_W-1:0] mem_alu;
  logic [DATA_W-1:0] mem_wdata;
  logic [REG_AW-1:0] mem_rd;

  modport master (
    output opcode, ex_ctrl, pc4, rdata1, rdata2, ext_imm, rt, rd,
           fwd_a, fwd_b, fwd_mem, fwd_wb,
    input  ctrl, mem_ctrl, mem_target, mem_zero, mem_alu, mem_wdata, mem_rd
  );

  modport slave (
    input  opcode, ex_ctrl, pc4, rdata1, rdata2, ext_imm, rt, rd,
           fwd_a, fwd_b, fwd_mem, fwd_wb,
    output ctrl, mem_ctrl, mem_target, mem_zero, mem_alu, mem_wdata, mem_rd
  );
endinterface

// File: rtl/control_execute_stage.sv
// Main decoder, EX stage (forwarding, ALU, branch target, dest select) and
// EX/MEM pipeline register of the 16-bit 5-stage CPU.
module control_execute_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  control_execute_stage_if.slave  cx
);

  typedef struct packed {
    logic       regdst;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
  } ctrl_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NOR, ALU_XOR
  } alu_op_e;

  ctrl_t             w_ctrl;
  ctrl_t             w_ex;
  alu_op_e           w_alu_op;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_target;
  logic [REG_AW-1:0] w_dest;

  logic [4:0]        r_mem_ctrl;
  logic [DATA_W-1:0] r_mem_target;
  logic              r_mem_zero;
  logic [DATA_W-1:0] r_mem_alu;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [REG_AW-1:0] r_mem_rd;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_ctrl = '0;
    case (cx.opcode)
      4'b0000: w_ctrl = 9'b100010001;
      4'b0001: w_ctrl = 9'b001100011;
      4'b0010: w_ctrl = 9'b000000110;
      4'b0011: w_ctrl = 9'b010001000;
      4'b0100: w_ctrl = 9'b000000011;
      default: w_ctrl = '0;
    endcase
  end

  assign cx.ctrl = w_ctrl;
  assign w_ex    = ctrl_t'(cx.ex_ctrl);

  // Select 11 falls back to the register value, same as 00.
  always_comb begin
    w_op_a = cx.rdata1;
    case (cx.fwd_a)
      2'b01:   w_op_a = cx.fwd_wb;
      2'b10:   w_op_a = cx.fwd_mem;
      default: w_op_a = cx.rdata1;
    endcase
    w_fwd_b = cx.rdata2;
    case (cx.fwd_b)
      2'b01:   w_fwd_b = cx.fwd_wb;
      2'b10:   w_fwd_b = cx.fwd_mem;
      default: w_fwd_b = cx.rdata2;
    endcase
  end

  assign w_op_b = w_ex.alusrc ? cx.ext_imm : w_fwd_b;

  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_ex.aluop)
      2'b01: w_alu_op = ALU_SUB;
      2'b10: begin
        case (cx.ext_imm[2:0])
          3'b001:  w_alu_op = ALU_SUB;
          3'b010:  w_alu_op = ALU_AND;
          3'b011:  w_alu_op = ALU_OR;
          3'b100:  w_alu_op = ALU_SLT;
          3'b101:  w_alu_op = ALU_NOR;
          3'b110:  w_alu_op = ALU_XOR;
          default: w_alu_op = ALU_ADD;
        endcase
      end
      default: w_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (w_alu_op)
      ALU_SUB: w_alu = w_op_a - w_op_b;
      ALU_AND: w_alu = w_op_a & w_op_b;
      ALU_OR:  w_alu = w_op_a | w_op_b;
      ALU_SLT: w_alu = DATA_W'($signed(w_op_a) < $signed(w_op_b));
      ALU_NOR: w_alu = ~(w_op_a | w_op_b);
      ALU_XOR: w_alu = w_op_a ^ w_op_b;
      default: w_alu = w_op_a + w_op_b;
    endcase
  end

  assign w_target = cx.pc4 + {cx.ext_imm[DATA_W-2:0], 1'b0};
  assign w_dest   = w_ex.regdst ? cx.rd : cx.rt;

  // NOTE: pipeline state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_ctrl   <= '0;
      r_mem_target <= '0;
      r_mem_zero   <= 1'b0;
      r_mem_alu    <= '0;
      r_mem_wdata  <= '0;
      r_mem_rd     <= '0;
    end else begin
      r_mem_ctrl   <= {w_ex.branch, w_ex.memread, w_ex.memwrite,
                       w_ex.memtoreg, w_ex.regwrite};
      r_mem_target <= w_target;
      r_mem_zero   <= (w_alu == '0);
      r_mem_alu    <= w_alu;
      r_mem_wdata  <= w_fwd_b;
      r_mem_rd     <= w_dest;
    end
  end

  assign cx.mem_ctrl   = r_mem_ctrl;
  assign cx.mem_target = r_mem_target;
  assign cx.mem_zero   = r_mem_zero;
  assign cx.mem_alu    = r_mem_alu;
  assign cx.mem_wdata  = r_mem_wdata;
  assign cx.mem_rd     = r_mem_rd;

endmodule

// File: tb/tb_control_execute_stage.sv
// Self-checking bench for control_execute_stage: decode table, EX/MEM vector
// table, and hand-written asynchronous reset sequences.
module tb_control_execute_stage;
  localparam int DW = 16;
  localparam int AW = 3;

  localparam logic [8:0] C_R    = 9'b100010001;
  localparam logic [8:0] C_LW   = 9'b001100011;
  localparam logic [8:0] C_SW   = 9'b000000110;
  localparam logic [8:0] C_BEQ  = 9'b010001000;
  localparam logic [8:0] C_ADDI = 9'b000000011;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  control_execute_stage_if #(.DATA_W(DW), .REG_AW(AW)) cx ();

  control_execute_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .cx      (cx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] opcode;
    logic [8:0] exp_ctrl;
  } dec_vec_t;

  typedef struct {
    logic [8:0]    ex_ctrl;
    logic [DW-1:0] pc4, rdata1, rdata2, ext_imm;
    logic [AW-1:0] rt, rd;
    logic [1:0]    fwd_a, fwd_b;
    logic [DW-1:0] fwd_mem, fwd_wb;
    logic [4:0]    exp_ctrl;
    logic [DW-1:0] exp_target;
    logic          exp_zero;
    logic [DW-1:0] exp_alu, exp_wdata;
    logic [AW-1:0] exp_rd;
  } ex_vec_t;

  dec_vec_t dec_vecs[6];
  ex_vec_t  ex_vecs[17];

  function automatic ex_vec_t mk(
    input logic [8:0] c, input logic [DW-1:0] pc4, r1, r2, imm,
    input logic [AW-1:0] rt, rd, input logic [1:0] fa, fb,
    input logic [DW-1:0] fm, fw,
    input logic [4:0] ec, input logic [DW-1:0] et, input logic ez,
    input logic [DW-1:0] ea, ew, input logic [AW-1:0] er);
    ex_vec_t v;
    v.ex_ctrl = c;  v.pc4 = pc4; v.rdata1 = r1; v.rdata2 = r2; v.ext_imm = imm;
    v.rt = rt; v.rd = rd; v.fwd_a = fa; v.fwd_b = fb; v.fwd_mem = fm; v.fwd_wb = fw;
    v.exp_ctrl = ec; v.exp_target = et; v.exp_zero = ez;
    v.exp_alu = ea; v.exp_wdata = ew; v.exp_rd = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input ex_vec_t v);
    cx.ex_ctrl = v.ex_ctrl; cx.pc4 = v.pc4; cx.rdata1 = v.rdata1; cx.rdata2 = v.rdata2;
    cx.ext_imm = v.ext_imm; cx.rt = v.rt; cx.rd = v.rd; cx.fwd_a = v.fwd_a;
    cx.fwd_b = v.fwd_b; cx.fwd_mem = v.fwd_mem; cx.fwd_wb = v.fwd_wb;
  endtask

  task automatic check_mem(input string tag, input ex_vec_t v);
    check({tag, ".mem_ctrl"},   32'(cx.mem_ctrl),   32'(v.exp_ctrl));
    check({tag, ".mem_target"}, 32'(cx.mem_target), 32'(v.exp_target));
    check({tag, ".mem_zero"},   32'(cx.mem_zero),   32'(v.exp_zero));
    check({tag, ".mem_alu"},    32'(cx.mem_alu),    32'(v.exp_alu));
    check({tag, ".mem_wdata"},  32'(cx.mem_wdata),  32'(v.exp_wdata));
    check({tag, ".mem_rd"},     32'(cx.mem_rd),     32'(v.exp_rd));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".mem_ctrl"},   32'(cx.mem_ctrl),   32'h0);
    check({tag, ".mem_target"}, 32'(cx.mem_target), 32'h0);
    check({tag, ".mem_zero"},   32'(cx.mem_zero),   32'h0);
    check({tag, ".mem_alu"},    32'(cx.mem_alu),    32'h0);
    check({tag, ".mem_wdata"},  32'(cx.mem_wdata),  32'h0);
    check({tag, ".mem_rd"},     32'(cx.mem_rd),     32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    dec_vecs[0] = '{4'b0000, C_R};
    dec_vecs[1] = '{4'b0001, C_LW};
    dec_vecs[2] = '{4'b0010, C_SW};
    dec_vecs[3] = '{4'b0011, C_BEQ};
    dec_vecs[4] = '{4'b0100, C_ADDI};
    dec_vecs[5] = '{4'b1111, 9'b000000000};

    //             ctrl    pc4      rdata1   rdata2   ext_imm  rt rd fa fb fwd_mem  fwd_wb   exp_ctrl  target  z  alu      wdata    rd
    ex_vecs[0]  = mk(C_R,    16'h0020,16'd5,   16'd7,   16'h0000,2, 3, 0, 0, 16'h0,   16'h0,   5'b00001, 16'h0020,0, 16'd12,  16'd7,   3);
    ex_vecs[1]  = mk(C_BEQ,  16'h0010,16'd9,   16'd9,   16'hFFFE,4, 5, 0, 0, 16'h0,   16'h0,   5'b10000, 16'h000C,1, 16'h0,   16'd9,   4);
    ex_vecs[2]  = mk(C_R,    16'h0000,16'd50,  16'd60,  16'h0001,1, 6, 2, 1, 16'd100, 16'd1,   5'b00001, 16'h0002,0, 16'd99,  16'd1,   6);
    ex_vecs[3]  = mk(C_SW,   16'h0040,16'h0100,16'h0055,16'h0004,7, 1, 0, 2, 16'hABCD,16'h0,   5'b00100, 16'h0048,0, 16'h0104,16'hABCD,7);
    ex_vecs[4]  = mk(C_ADDI, 16'hFFFE,16'hFFFF,16'h0003,16'h0001,2, 5, 0, 0, 16'h0,   16'h0,   5'b00001, 16'h0000,1, 16'h0000,16'h0003,2);
    ex_vecs[5]  = mk(C_R,    16'h0000,16'h8000,16'h0001,16'h0004,0, 1, 0, 0, 16'h0,   16'h0,   5'b00001, 16'h0008,0, 16'h0001,16'h0001,1);
    ex_vecs[6]  = mk(C_R,    16'h0000,16'h0001,16'h8000,16'h0004,0, 1, 0, 0, 16'h0,   16'h0,   5'b00001, 16'h0008,1, 16'h0000,16'h8000,1);
    ex_vecs[7]  = mk(C_R,    16'h0100,16'hF0F0,16'h3C3C,16'h0002,0, 2, 0, 0, 16'h0,   16'h0,   5'b00001, 16'h0104,0, 16'h3030,16'h3C3C,2);
    ex_vecs[8]  = mk(C_R,    16'h0000,16'hF0F0,16'h0F00,16'h0003,0, 2, 0, 0, 16'h0,   16'h0,   5'b00001, 16'h0006,0, 16'hFFF0,16'h0F00,2);
    ex_vecs[9]  = mk(C_R,    16'h0000,16'hF0F0,16'h0F0F,16'h0005,0, 2, 0, 0, 16'h0,   16'h0,   5'b00001, 16'h000A,1, 16'h0000,16'h0F0F,2);
    ex_vecs[10] = mk(C_R,    16'h0000,16'hAAAA,16'h5555,16'h0006,0, 2, 0, 0, 16'h0,   16'h0,   5'b00001, 16'h000C,0, 16'hFFFF,16'h5555,2);
    ex_vecs[11] = mk(C_R,    16'h0000,16'd2,   16'd3,   16'h0007,0, 2, 0, 0, 16'h0,   16'h0,   5'b00001, 16'h000E,0, 16'd5,   16'd3,   2);
    ex_vecs[12] = mk(C_LW,   16'h0050,16'h0200,16'h0011,16'hFFFC,3, 6, 0, 0, 16'h0,   16'h0,   5'b01011, 16'h0048,0, 16'h01FC,16'h0011,3);
    ex_vecs[13] = mk(C_R,    16'h0000,16'd1,   16'd2,   16'h0000,0, 4, 3, 3, 16'h7777,16'h8888,5'b00001, 16'h0000,0, 16'd3,   16'd2,   4);
    ex_vecs[14] = mk(C_BEQ,  16'h0020,16'd5,   16'd3,   16'h0003,1, 5, 0, 0, 16'h0,   16'h0,   5'b10000, 16'h0026,0, 16'd2,   16'd3,   1);
    ex_vecs[15] = mk(9'h000, 16'h0000,16'd1,   16'd1,   16'h0000,5, 6, 0, 0, 16'h0,   16'h0,   5'b00000, 16'h0000,0, 16'd2,   16'd1,   5);
    ex_vecs[16] = mk(9'b000011000,16'h0000,16'd7,16'd8, 16'h0001,5, 6, 1, 0, 16'h0,   16'd9,   5'b00000, 16'h0002,0, 16'd17,  16'd8,   5);

    cx.opcode = 4'b0000;
    apply(ex_vecs[0]);
    reset_n = 1'b0;

    // Reset state, and the decoder is combinational even while in reset.
    #2;
    check_zero("reset");
    for (int i = 0; i < 6; i++) begin
      cx.opcode = dec_vecs[i].opcode;
      #1;
      check($sformatf("decode[%0d]", i), 32'(cx.ctrl), 32'(dec_vecs[i].exp_ctrl));
    end
    @(posedge clock); #1;
    check_zero("reset_held");
    #3 reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(ex_vecs[i]);
      @(posedge clock); #1;
      check_mem($sformatf("vec[%0d]", i), ex_vecs[i]);
    end

    // Asynchronous reset mid-cycle, held across an edge, then released.
    cx.opcode = 4'b0001;
    #2 reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    check("ctrl_in_reset", 32'(cx.ctrl), 32'(C_LW));
    apply(ex_vecs[3]);
    @(posedge clock); #1;
    check_zero("reset_edge");
    #2 reset_n = 1'b1;
    #1;
    check_zero("release_no_edge");
    @(posedge clock); #1;
    check_mem("after_release", ex_vecs[3]);
    apply(ex_vecs[1]);
    @(posedge clock); #1;
    check_mem("after_release2", ex_vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
